// File: rtl/mult_arb_pkg.sv
// Shared types and constants for arbitration in front of the pipelined multiplier.
package mult_arb_pkg;

    localparam int unsigned MULT_STAGES = 8;
    localparam int unsigned MULT_WIDTH  = 64;
    localparam int unsigned TAG_ID_W    = 3;
    localparam int unsigned MAX_REQ     = 1 << TAG_ID_W;

    // Owner of one in-flight multiply; id wide enough for up to eight requesters.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } mult_tag_t;

    function automatic logic [MAX_REQ-1:0] onehot_of(input logic [TAG_ID_W-1:0] id);
        logic [MAX_REQ-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping upward.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    int   idx;
    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < int'(N); off++) begin
            idx = int'(ptr) + off;
            if (idx >= int'(N)) begin
                idx = idx - int'(N);
            end
            if (!found && req[IW'(idx)]) begin
                found           = 1'b1;
                gnt[IW'(idx)]   = 1'b1;
                gnt_id          = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters and routes each product back to its issuer.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned STAGES  = MULT_STAGES,
    parameter int unsigned WIDTH   = MULT_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_mcand,
    input  logic [NUM_REQ*WIDTH-1:0] req_mplier,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_product,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_mcand,
    output logic [WIDTH-1:0]         mul_mplier,
    input  logic [WIDTH-1:0]         mul_product,
    input  logic                     mul_done,
    output logic                     busy,
    output logic                     tag_error
);

    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     gnt_id;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_gnt;
    mult_tag_t          tags [STAGES];
    mult_tag_t          tail;
    logic               tail_fire;
    logic               any_tag;

    // No grants while reset is held.
    assign arb_req = reset ? '0 : req;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req    (arb_req),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .gnt_id (gnt_id)
    );

    assign gnt       = arb_gnt;
    assign mul_start = |arb_gnt;

    // Operand mux; zero when nothing is granted.
    always_comb begin
        mul_mcand  = '0;
        mul_mplier = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (arb_gnt[i]) begin
                mul_mcand  = req_mcand[i*WIDTH +: WIDTH];
                mul_mplier = req_mplier[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (mul_start) begin
            rr_ptr <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
        end
    end

    // Owner tags travel alongside the multiplier so the tail lines up with mul_done.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                tags[k] <= '0;
            end
        end else begin
            tags[0] <= '{valid: mul_start, id: TAG_ID_W'(gnt_id)};
            for (int k = 1; k < int'(STAGES); k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    assign tail      = tags[STAGES-1];
    assign tail_fire = !reset && tail.valid && mul_done;

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            resp_valid[i] = tail_fire && (tail.id == TAG_ID_W'(i));
        end
    end

    assign resp_product = mul_product;

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_error <= 1'b0;
        end else if (mul_done != tail.valid) begin
            tag_error <= 1'b1;
        end
    end

    always_comb begin
        any_tag = 1'b0;
        for (int k = 0; k < int'(STAGES); k++) begin
            any_tag = any_tag | tags[k].valid;
        end
    end

    assign busy = (|req) | any_tag;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter with an in-bench multiplier and a cycle-level reference model.
module tb_mult_share_arbiter;
    import mult_arb_pkg::*;

    localparam int N  = 4;
    localparam int ST = MULT_STAGES;
    localparam int W  = MULT_WIDTH;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_mcand;
    logic [N*W-1:0]   req_mplier;
    logic [N-1:0]     gnt;
    logic [N-1:0]     resp_valid;
    logic [W-1:0]     resp_product;
    logic             mul_start;
    logic [W-1:0]     mul_mcand;
    logic [W-1:0]     mul_mplier;
    logic [W-1:0]     mul_product;
    logic             mul_done;
    logic             busy;
    logic             tag_error;
    logic             force_done;

    mult_share_arbiter #(.NUM_REQ(N), .STAGES(ST), .WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_mcand    (req_mcand),
        .req_mplier   (req_mplier),
        .gnt          (gnt),
        .resp_valid   (resp_valid),
        .resp_product (resp_product),
        .mul_start    (mul_start),
        .mul_mcand    (mul_mcand),
        .mul_mplier   (mul_mplier),
        .mul_product  (mul_product),
        .mul_done     (mul_done),
        .busy         (busy),
        .tag_error    (tag_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Multiplier stand-in: fixed ST-cycle latency, shares the reset.
    logic         pv [ST];
    logic [W-1:0] pp [ST];
    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < ST; k++) begin
                pv[k] <= 1'b0;
                pp[k] <= '0;
            end
        end else begin
            pv[0] <= mul_start;
            pp[0] <= mul_mcand * mul_mplier;
            for (int k = 1; k < ST; k++) begin
                pv[k] <= pv[k-1];
                pp[k] <= pp[k-1];
            end
        end
    end
    assign mul_done    = pv[ST-1] | force_done;
    assign mul_product = pp[ST-1];

    // Reference model state and literal pins keyed by cycle number.
    int           m_ptr;
    bit           m_err;
    int           sched_id [int];
    logic [W-1:0] sched_prod [int];
    int           pin_gnt [int];
    int           pin_resp [int];
    logic [W-1:0] pin_prod [int];
    int           pin_terr [int];
    int           pin_busy [int];
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        int           g;
        int           i;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        bit           has;
        bit           pend;
        logic [W-1:0] a;
        logic [W-1:0] b;
        if (reset) begin
            chk("rst_gnt", W'(gnt), '0);
            chk("rst_start", W'(mul_start), '0);
            m_ptr = 0;
            m_err = 0;
            sched_id.delete();
            sched_prod.delete();
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (g < 0 && req[i]) g = i;
            end
            eg = '0;
            a  = '0;
            b  = '0;
            if (g >= 0) begin
                eg[g] = 1'b1;
                a     = req_mcand[g*W +: W];
                b     = req_mplier[g*W +: W];
            end
            chk("gnt", W'(gnt), W'(eg));
            chk("mul_start", W'(mul_start), W'(g >= 0));
            chk("mul_mcand", mul_mcand, a);
            chk("mul_mplier", mul_mplier, b);

            has = sched_id.exists(cyc);
            er  = '0;
            if (has && mul_done) er[sched_id[cyc]] = 1'b1;
            chk("resp_valid", W'(resp_valid), W'(er));
            if (has && mul_done) chk("resp_product", resp_product, sched_prod[cyc]);
            chk("tag_error", W'(tag_error), W'(m_err));
            pend = 1'b0;
            for (int k = 0; k < ST; k++) begin
                if (sched_id.exists(cyc + k)) pend = 1'b1;
            end
            chk("busy", W'(busy), W'((|req) || pend));

            if (pin_gnt.exists(cyc))  chk("pin_gnt", W'(gnt), W'(pin_gnt[cyc]));
            if (pin_resp.exists(cyc)) chk("pin_resp", W'(resp_valid), W'(pin_resp[cyc]));
            if (pin_prod.exists(cyc)) chk("pin_prod", resp_product, pin_prod[cyc]);
            if (pin_terr.exists(cyc)) chk("pin_tag_error", W'(tag_error), W'(pin_terr[cyc]));
            if (pin_busy.exists(cyc)) chk("pin_busy", W'(busy), W'(pin_busy[cyc]));

            if (mul_done != has) m_err = 1'b1;
            if (has) begin
                sched_id.delete(cyc);
                sched_prod.delete(cyc);
            end
            if (g >= 0) begin
                sched_id[cyc + ST]   = g;
                sched_prod[cyc + ST] = a * b;
                m_ptr = (g + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        req_mcand[idx*W +: W]  = a;
        req_mplier[idx*W +: W] = b;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req   = '0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        int           t;
        logic [N-1:0] lg;
        reset      = 1'b1;
        req        = '0;
        req_mcand  = '0;
        req_mplier = '0;
        force_done = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        pin_busy[cyc] = 0;
        pin_terr[cyc] = 0;
        pin_resp[cyc] = 0;
        repeat (2) step();

        // Single requester, 3*5.
        t = cyc;
        req = 4'b0010;
        set_op(1, 64'd3, 64'd5);
        pin_gnt[t]      = 2;
        pin_resp[t + 7] = 0;
        pin_resp[t + 8] = 2;
        pin_prod[t + 8] = 64'd15;
        pin_resp[t + 9] = 0;
        step();
        req = '0;
        repeat (10) step();

        // All four requesting: rotation and squares 4, 9, 16, 25.
        do_reset(2);
        t = cyc;
        for (int i = 0; i < N; i++) set_op(i, W'(i + 2), W'(i + 2));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            pin_gnt[t + k]      = 1 << (k % 4);
            pin_resp[t + 8 + k] = 1 << (k % 4);
            pin_prod[t + 8 + k] = W'(((k % 4) + 2) * ((k % 4) + 2));
        end
        repeat (16) step();
        req = '0;
        repeat (10) step();

        // Fairness after pointer moves to 2.
        do_reset(1);
        req = 4'b0010;
        pin_gnt[cyc] = 2;
        step();
        req = 4'b1011;
        pin_gnt[cyc] = 8;
        step();
        pin_gnt[cyc] = 1;
        step();
        req = '0;
        repeat (10) step();

        // Reset while three operations are in flight.
        do_reset(1);
        t = cyc;
        req = 4'b0001; step();
        req = 4'b0010; step();
        req = 4'b0100; step();
        req = '0;      step();
        do_reset(1);
        pin_busy[t + 5] = 0;
        pin_terr[t + 5] = 0;
        for (int k = 8; k <= 10; k++) pin_resp[t + k] = 0;
        repeat (10) step();

        // Spurious done with nothing in flight.
        t = cyc;
        force_done = 1'b1;
        pin_resp[t]     = 0;
        pin_terr[t + 1] = 1;
        pin_terr[t + 4] = 1;
        step();
        force_done = 1'b0;
        repeat (5) step();
        do_reset(1);

        // Large square interleaved with another requester.
        t = cyc;
        req = 4'b0001;
        set_op(0, 64'd7, 64'd11);
        pin_gnt[t]      = 1;
        pin_resp[t + 8] = 1;
        pin_prod[t + 8] = 64'd77;
        step();
        req = 4'b0100;
        set_op(2, 64'd65536, 64'd65536);
        pin_gnt[t + 1]  = 4;
        pin_resp[t + 9] = 4;
        pin_prod[t + 9] = 64'd4294967296;
        step();
        req = 4'b0001;
        set_op(0, 64'd100, 64'd3);
        pin_resp[t + 10] = 1;
        pin_prod[t + 10] = 64'd300;
        step();
        req = '0;
        repeat (12) step();

        // Random traffic: requests held until granted, occasional resets.
        for (int it = 0; it < 3000; it++) begin
            @(negedge clock);
            lg = gnt;
            step();
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1 + int'($urandom_range(0, 2)));
                continue;
            end
            for (int i = 0; i < N; i++) begin
                if (req[i] && lg[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    set_op(i, {$urandom, $urandom}, {$urandom, $urandom});
                end
            end
        end
        req = '0;
        repeat (12) step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
